// File: rtl/lot_occupancy_counter.sv
// Parking-lot occupancy counter driven by an outer (a) and an inner (b) beam
// sensor. Each sensor is brought into the clock domain through two flops.
// The sensor-sequence FSM then follows the entry/exit orderings and keeps a
// saturating occupancy count.
// Optional feature: define DEBOUNCE_EN to insert a per-sensor debounce filter
// between the synchronizers and the FSM. That filter requires DEBOUNCE_CYCLES
// consecutive differing samples before it accepts a new level.
module lot_occupancy_counter #(
  parameter int unsigned CAPACITY        = 15,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [3:0] count,
  output logic       car_enter,
  output logic       car_exit,
  output logic       full,
  output logic       empty,
  output logic       seq_err
);

  localparam logic [3:0] CAP4 = 4'(CAPACITY);

  // Reject illegal parameter values while the design is elaborated.
  if (CAPACITY < 1 || CAPACITY > 15) begin : g_cap_chk
    $error("CAPACITY out of range 1..15");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_deb_chk
    $error("DEBOUNCE_CYCLES out of range 1..15");
  end

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR
  } state_t;

  logic a_meta_q, a_meta_d, a_sync_q, a_sync_d;
  logic b_meta_q, b_meta_d, b_sync_q, b_sync_d;
  logic fa, fb;

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       car_enter_q, car_enter_d;
  logic       car_exit_q, car_exit_d;
  logic       seq_err_q, seq_err_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;

  // Two-flop synchronizer inputs: shift each sensor down its chain.
  always_comb begin
    a_meta_d = sensor_a;
    a_sync_d = a_meta_q;
    b_meta_d = sensor_b;
    b_sync_d = b_meta_q;
  end

  // Synchronizer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
    end else begin
      a_meta_q <= a_meta_d;
      a_sync_q <= a_sync_d;
      b_meta_q <= b_meta_d;
      b_sync_q <= b_sync_d;
    end
  end

`ifdef DEBOUNCE_EN
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       fa_q, fa_d, fb_q, fb_d;
  logic [3:0] run_a_q, run_a_d, run_b_q, run_b_d;

  // Count consecutive samples that disagree with the filtered level. The
  // new level is taken on the DEBOUNCE_CYCLES-th such sample, and any
  // agreeing sample restarts the run.
  always_comb begin
    fa_d    = fa_q;
    fb_d    = fb_q;
    run_a_d = '0;
    run_b_d = '0;
    if (a_sync_q != fa_q) begin
      if (run_a_q == DEB_LAST) fa_d = a_sync_q;
      else                     run_a_d = run_a_q + 4'd1;
    end
    if (b_sync_q != fb_q) begin
      if (run_b_q == DEB_LAST) fb_d = b_sync_q;
      else                     run_b_d = run_b_q + 4'd1;
    end
  end

  // Debounce filter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
      run_a_q <= '0;
      run_b_q <= '0;
    end else begin
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      run_a_q <= run_a_d;
      run_b_q <= run_b_d;
    end
  end

  assign fa = fa_q;
  assign fb = fb_q;
`else
  assign fa = a_sync_q;
  assign fb = b_sync_q;
`endif

  // Next-state and output decode. Each state has a pattern it holds on,
  // a pattern that advances it and a pattern that backs it up. Every other
  // pattern aborts to WAIT_CLR.
  always_comb begin
    logic       err;
    logic       done_en;
    logic       done_ex;
    logic [1:0] pat;
    pat         = {fa, fb};
    err         = 1'b0;
    done_en     = 1'b0;
    done_ex     = 1'b0;
    state_d     = state_q;
    count_d     = count_q;
    car_enter_d = 1'b0;
    car_exit_d  = 1'b0;
    seq_err_d   = 1'b0;
    unique case (state_q)
      IDLE: case (pat)
        2'b10:   state_d = EN1;
        2'b01:   state_d = EX1;
        2'b11:   err = 1'b1;
        default: ;
      endcase
      EN1: case (pat)
        2'b11:   state_d = EN2;
        2'b00:   state_d = IDLE;
        2'b01:   err = 1'b1;
        default: ;
      endcase
      EN2: case (pat)
        2'b01:   state_d = EN3;
        2'b10:   state_d = EN1;
        2'b00:   err = 1'b1;
        default: ;
      endcase
      EN3: case (pat)
        2'b00:   begin state_d = IDLE; done_en = 1'b1; end
        2'b11:   state_d = EN2;
        2'b10:   err = 1'b1;
        default: ;
      endcase
      EX1: case (pat)
        2'b11:   state_d = EX2;
        2'b00:   state_d = IDLE;
        2'b10:   err = 1'b1;
        default: ;
      endcase
      EX2: case (pat)
        2'b10:   state_d = EX3;
        2'b01:   state_d = EX1;
        2'b00:   err = 1'b1;
        default: ;
      endcase
      EX3: case (pat)
        2'b00:   begin state_d = IDLE; done_ex = 1'b1; end
        2'b11:   state_d = EX2;
        2'b01:   err = 1'b1;
        default: ;
      endcase
      WAIT_CLR: if (pat == 2'b00) state_d = IDLE;
    endcase

    if (err) begin
      state_d   = WAIT_CLR;
      seq_err_d = 1'b1;
    end
    if (done_en) begin
      if (count_q < CAP4) begin
        count_d     = count_q + 4'd1;
        car_enter_d = 1'b1;
      end else begin
        seq_err_d = 1'b1;
      end
    end
    if (done_ex) begin
      if (count_q != 4'd0) begin
        count_d    = count_q - 4'd1;
        car_exit_d = 1'b1;
      end else begin
        seq_err_d = 1'b1;
      end
    end
    full_d  = (count_d == CAP4);
    empty_d = (count_d == 4'd0);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      car_enter_q <= 1'b0;
      car_exit_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      car_enter_q <= car_enter_d;
      car_exit_q  <= car_exit_d;
      seq_err_q   <= seq_err_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  assign count     = count_q;
  assign car_enter = car_enter_q;
  assign car_exit  = car_exit_q;
  assign seq_err   = seq_err_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule
